// File: rtl/sysarray_result_drain.sv
// Result drain for the systolic GEMM array: captures skewed per-PE results and
// re-emits complete rows in order, one NUM-word beat per row, on a valid/ready stream.
module sysarray_result_drain #(
   parameter int WL  = 32,
   parameter int NUM = 16,
   parameter int RW  = $clog2(NUM)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM*NUM-1:0]    resultvalid,
   input  logic [WL*NUM*NUM-1:0] resultvalue,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WL*NUM-1:0]     out_data,
   output logic [RW-1:0]         out_row,
   output logic                  out_last,
   output logic                  busy,
   output logic                  overflow
);

   localparam int NPE = NUM * NUM;

   logic [NPE*WL-1:0] cap;
   logic [NPE-1:0]    pend;
   logic [RW-1:0]     ptr;
   logic              overflow_q;
   logic [NPE-1:0]    pop_mask;
   logic              pop;
   logic              drop;

   // Row mux keyed on ptr only, so outputs never depend on resultvalid or out_ready.
   always_comb begin
      out_valid = 1'b0;
      out_data  = '0;
      for (int r = 0; r < NUM; r++) begin
         if (ptr == RW'(r)) begin
            out_valid = &pend[r*NUM +: NUM];
            out_data  = cap[r*NUM*WL +: NUM*WL];
         end
      end
   end

   assign pop = out_valid & out_ready;

   always_comb begin
      pop_mask = '0;
      for (int r = 0; r < NUM; r++) begin
         pop_mask[r*NUM +: NUM] = {NUM{pop && (ptr == RW'(r))}};
      end
   end

   // A pending PE is only reloadable in the cycle its row pops; otherwise the strobe is lost.
   assign drop = |(resultvalid & pend & ~pop_mask);

   always_ff @(posedge clk) begin
      if (rst) begin
         cap        <= '0;
         pend       <= '0;
         ptr        <= '0;
         overflow_q <= 1'b0;
      end else begin
         for (int k = 0; k < NPE; k++) begin
            if (resultvalid[k] && (!pend[k] || pop_mask[k])) begin
               cap[k*WL +: WL] <= resultvalue[k*WL +: WL];
               pend[k]         <= 1'b1;
            end else if (pop_mask[k]) begin
               pend[k] <= 1'b0;
            end
         end
         if (drop) overflow_q <= 1'b1;
         if (pop) ptr <= (ptr == RW'(NUM-1)) ? '0 : ptr + 1'b1;
      end
   end

   assign out_row  = ptr;
   assign out_last = (ptr == RW'(NUM-1));
   assign busy     = |pend;
   assign overflow = overflow_q;

endmodule
